reverse_requester: RTL and testbench
====================================

Name: reverse_requester

Overview:
- Initiator side of the reverse core's start/Done protocol.
- Accepts operands on a valid/ready input stream and issues one job at a time to a reverse core: drives `start` and `x`, then waits for `Done`.
- Captures `reverse` and returns the operand/result pair on a valid/ready output stream.
- Adds a watchdog timeout and a job counter. Sits between a host/stimulus stream and one reverse core instance.

Parameters:
- WIDTH, 16, width of operand and result.
- TIMEOUT, 1024, max cycles spent in WAIT before aborting a job (must be ≥ 2).
- CNT_W, 16, width of the completed-job counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  requester can accept an operand.
- in_x  in  WIDTH  operand.
- core_start  out  1  one-cycle start pulse to the reverse core.
- core_x  out  WIDTH  operand to the core; held stable for the whole job.
- core_done  in  1  core Done pulse; core_reverse is valid in this cycle.
- core_reverse  in  WIDTH  core result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_x  out  WIDTH  operand that produced the result.
- out_reverse  out  WIDTH  captured result; 0 on timeout.
- out_timeout  out  1  result was aborted by the watchdog.
- busy  out  1  state is not IDLE.
- spurious  out  1  sticky flag: core_done was seen outside WAIT.
- job_cnt  out  CNT_W  count of output handshakes (success or timeout); wraps modulo 2^CNT_W.

Behaviour:
- Reset values: state IDLE, in_ready=1, core_start=0, core_x=0, out_valid=0, out_x=0, out_reverse=0, out_timeout=0, busy=0, spurious=0, job_cnt=0, timer=0.
- Reset is asynchronous and may be asserted mid-job. It returns the block to IDLE immediately and core_start drops. The core must share the same reset.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_x into x_reg and go to ISSUE.
- ISSUE:
  - core_start=1 for exactly one cycle.
  - timer cleared to 0.
  - Next state WAIT.
- WAIT:
  - If core_done: capture core_reverse into out_reverse, out_timeout=0, go to OUT.
  - Else if timer==TIMEOUT-1: out_reverse=0, out_timeout=1, go to OUT.
  - Else timer increments.
  - core_done wins if it coincides with the timeout cycle.
- OUT:
  - out_valid=1, in_ready=0.
  - out_x, out_reverse and out_timeout are held stable until out_ready.
  - On out_valid&out_ready: job_cnt+1 and go to IDLE.
  - A new operand can be accepted the cycle after the output handshake, not the same cycle.
- core_x is driven from x_reg continuously, so it is stable from the ISSUE cycle until after OUT.
- core_start is asserted only in ISSUE; there is never more than one outstanding job.
- core_done is sampled only in WAIT. If seen in IDLE, ISSUE or OUT, it is ignored for data and sets spurious, which stays set until reset.
- Latency:
  - Input handshake at cycle t gives core_start at t+1.
  - core_done sampled at cycle d gives out_valid at d+1.
  - Timeout gives out_valid exactly TIMEOUT+1 cycles after core_start.
- Output is registered; no combinational path from inputs to outputs except in_ready/out_valid, which decode the registered state.
- Width rule: all data paths are WIDTH bits with no extension. The timer is $clog2(TIMEOUT) bits wide.

Decomposition:
- Shared package reverse_pkg:
  - state enum req_state_e {IDLE, ISSUE, WAIT, OUT};
  - default WIDTH constant;
  - TIMEOUT default constant.
- One natural sub-module: reverse_watchdog.
  - Parameterised timer with clear/enable inputs and an expire output.
  - Instanced once; the FSM, capture registers and counter stay in reverse_requester.

Test Plan:
- Bench model core: Done 5 cycles after start, returns the decimal digit reversal. in_x=1234 → core_start one cycle after handshake; out_valid with out_x=1234, out_reverse=4321, out_timeout=0; job_cnt=1.
- Back-to-back operands 120, 7, 9000, out_ready always high → results 21, 7, 9 in order. in_ready=0 from acceptance until the cycle after each output handshake. job_cnt=3.
- Output backpressure: out_ready low for 10 cycles after out_valid → out_x/out_reverse held; in_ready stays 0; core_start never re-pulses; core_x unchanged.
- TIMEOUT=8, model core never asserts Done → out_valid exactly 9 cycles after core_start, out_reverse=0, out_timeout=1. A following job (x=56) completes normally with result 65.
- core_done in IDLE, and core_done coincident with the timeout cycle → spurious=1 and no output in the first case. In the second case the result is captured with out_timeout=0.
- rst asserted while in WAIT → all outputs return to reset values asynchronously. After release, a new job x=801 gives 108 correctly.

Source files
------------

// File: rtl/reverse_pkg.sv
// Shared types and default sizing for the reverse-core requester slice.
package reverse_pkg;

    localparam int unsigned WIDTH_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 1024;
    localparam int unsigned CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } req_state_e;

endpackage

// File: rtl/reverse_watchdog.sv
// Clearable cycle timer that flags when TIMEOUT-1 cycles have been counted.
module reverse_watchdog #(
    parameter int unsigned TIMEOUT = reverse_pkg::TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (enable && !expire_c) begin
            timer <= timer + TW'(1);
        end
    end

    assign expire_c = (timer == TW'(TIMEOUT - 1));

endmodule

// File: rtl/reverse_requester.sv
// Issues one job at a time to a reverse core and returns operand/result pairs,
// with a watchdog abort, a sticky spurious-Done flag and a completed-job counter.
module reverse_requester
    import reverse_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    output logic             core_start,
    output logic [WIDTH-1:0] core_x,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_reverse,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_reverse,
    output logic             out_timeout,
    output logic             busy,
    output logic             spurious,
    output logic [CNT_W-1:0] job_cnt
);

    req_state_e state, state_next;

    logic [WIDTH-1:0] x_reg;
    logic             expire_c;
    logic             accept_c;
    logic             wd_clear_c;
    logic             wd_en_c;
    logic             cap_done_c;
    logic             cap_tmo_c;
    logic             out_hs_c;
    logic             spur_c;

    reverse_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (wd_clear_c),
        .enable   (wd_en_c),
        .expire_c (expire_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; Done has priority over the watchdog in WAIT
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (core_done || expire_c) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        accept_c   = 1'b0;
        wd_clear_c = 1'b0;
        wd_en_c    = 1'b0;
        cap_done_c = 1'b0;
        cap_tmo_c  = 1'b0;
        out_hs_c   = 1'b0;
        case (state)
            IDLE:  accept_c = in_valid;
            ISSUE: wd_clear_c = 1'b1;
            WAIT: begin
                if (core_done) begin
                    cap_done_c = 1'b1;
                end else if (expire_c) begin
                    cap_tmo_c = 1'b1;
                end else begin
                    wd_en_c = 1'b1;
                end
            end
            OUT:     out_hs_c = out_ready;
            default: accept_c = 1'b0;
        endcase
        spur_c = core_done && (state != WAIT);
    end

    // Registered handshake/status outputs follow the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready   <= 1'b1;
            core_start <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            in_ready   <= (state_next == IDLE);
            core_start <= (state_next == ISSUE);
            out_valid  <= (state_next == OUT);
            busy       <= (state_next != IDLE);
        end
    end

    // Operand, result capture, sticky flag and job counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg       <= '0;
            out_x       <= '0;
            out_reverse <= '0;
            out_timeout <= 1'b0;
            spurious    <= 1'b0;
            job_cnt     <= '0;
        end else begin
            if (accept_c) begin
                x_reg <= in_x;
            end
            if (cap_done_c) begin
                out_x       <= x_reg;
                out_reverse <= core_reverse;
                out_timeout <= 1'b0;
            end else if (cap_tmo_c) begin
                out_x       <= x_reg;
                out_reverse <= '0;
                out_timeout <= 1'b1;
            end
            if (spur_c) begin
                spurious <= 1'b1;
            end
            if (out_hs_c) begin
                job_cnt <= job_cnt + CNT_W'(1);
            end
        end
    end

    assign core_x = x_reg;

endmodule

// File: tb/tb_reverse_requester.sv
// Scoreboard bench for reverse_requester with a behavioural digit-reversing core.
module tb_reverse_requester;

    localparam int unsigned W  = 16;
    localparam int unsigned TO = 8;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_x = '0;
    logic          core_done = 1'b0;
    logic [W-1:0]  core_reverse = '0;
    logic          out_ready = 1'b1;
    logic          in_ready, core_start, out_valid, out_timeout, busy, spurious;
    logic [W-1:0]  core_x, out_x, out_reverse;
    logic [CW-1:0] job_cnt;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] rv;
        logic         tmo;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   delay_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   exp_jobs = 0;
    bit   exp_spur = 1'b0;
    int   rdy_mode = 0;
    bit   inject_req = 1'b0;

    reverse_requester #(
        .WIDTH   (W),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .core_start   (core_start),
        .core_x       (core_x),
        .core_done    (core_done),
        .core_reverse (core_reverse),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_reverse  (out_reverse),
        .out_timeout  (out_timeout),
        .busy         (busy),
        .spurious     (spurious),
        .job_cnt      (job_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (tests=%0d)", tests);
        $fatal(1, "global timeout");
    end

    function automatic logic [W-1:0] dec_rev(input int unsigned v);
        int unsigned r = 0;
        while (v != 0) begin
            r = r * 10 + v % 10;
            v = v / 10;
        end
        return W'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset(input string t);
        chk({t, ".in_ready"}, 32'(in_ready), 1);
        chk({t, ".core_start"}, 32'(core_start), 0);
        chk({t, ".core_x"}, 32'(core_x), 0);
        chk({t, ".out_valid"}, 32'(out_valid), 0);
        chk({t, ".out_x"}, 32'(out_x), 0);
        chk({t, ".out_reverse"}, 32'(out_reverse), 0);
        chk({t, ".out_timeout"}, 32'(out_timeout), 0);
        chk({t, ".busy"}, 32'(busy), 0);
        chk({t, ".spurious"}, 32'(spurious), 0);
        chk({t, ".job_cnt"}, 32'(job_cnt), 0);
    endtask

    // Core model: Done after a per-job delay (<=0 means never), result = decimal reversal
    int core_cnt = -1;
    int core_delay = -1;
    always @(posedge clk) begin
        #1;
        core_done = 1'b0;
        if (rst) begin
            core_cnt = -1;
            delay_q.delete();
        end else begin
            if (core_start) begin
                core_cnt = 0;
                if (delay_q.size() > 0) core_delay = delay_q.pop_front();
                else core_delay = -1;
            end else if (core_cnt >= 0) begin
                core_cnt++;
            end
            if (core_cnt > 0 && core_cnt == core_delay) begin
                core_done    = 1'b1;
                core_reverse = dec_rev(32'(core_x));
                core_cnt     = -1;
            end
            if (inject_req) begin
                core_done    = 1'b1;
                core_reverse = 16'hBEEF;
                inject_req   = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: protocol timing and scoreboard pops on every output handshake
    bit pending = 1'b0;
    bit prev_ov = 1'b0;
    int start_due = -1;
    int last_start = 0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            pending   = 1'b0;
            prev_ov   = 1'b0;
            start_due = -1;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!pending));
            chk("busy", 32'(busy), 32'(pending));
            chk("core_start", 32'(core_start), 32'(cyc == start_due));
            chk("out_valid_unexpected", 32'(out_valid && !pending), 0);
            if (core_start) begin
                last_start = cyc;
                start_due  = -1;
            end
            if (out_valid && !prev_ov && sb.size() > 0) begin
                chk("latency", 32'(cyc - last_start), 32'(sb[0].lat));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    chk("out_x", 32'(out_x), 32'(e.x));
                    chk("out_reverse", 32'(out_reverse), 32'(e.rv));
                    chk("out_timeout", 32'(out_timeout), 32'(e.tmo));
                    chk("job_cnt", 32'(job_cnt), 32'(CW'(exp_jobs)));
                    chk("spurious", 32'(spurious), 32'(exp_spur));
                    exp_jobs++;
                end
                pending = 1'b0;
            end
            prev_ov = out_valid && !out_ready;
            if (in_valid && in_ready) begin
                pending   = 1'b1;
                start_due = cyc + 1;
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input int d);
        bit   ok = 1'b0;
        exp_t e;
        @(posedge clk);
        #1;
        in_x     = x;
        in_valid = 1'b1;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        chk("send_accept", 32'(ok), 1);
        if (ok) begin
            e.x   = x;
            e.tmo = (d < 1 || d > int'(TO));
            e.rv  = e.tmo ? '0 : dec_rev(32'(x));
            e.lat = e.tmo ? int'(TO) + 1 : d + 1;
            sb.push_back(e);
            delay_q.push_back(d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x     = '0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready && !out_valid) ok = 1'b1;
        end
        chk("wait_idle", 32'(ok), 1);
    endtask

    initial begin
        bit seen;
        #12;
        chk_reset("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        send(16'd1234, 5);
        wait_idle();
        chk("job_cnt_after_first", 32'(job_cnt), 1);

        send(16'd120, 5);
        send(16'd7, 5);
        send(16'd9000, 5);
        wait_idle();
        chk("job_cnt_after_b2b", 32'(job_cnt), 4);

        // Output backpressure: everything held while out_ready stays low
        rdy_mode = 2;
        send(16'd4242, 5);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("bp_out_valid_seen", 32'(seen), 1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_x", 32'(out_x), 4242);
            chk("bp_out_reverse", 32'(out_reverse), 2424);
            chk("bp_core_x", 32'(core_x), 4242);
        end
        rdy_mode = 0;
        wait_idle();

        send(16'd777, -1);
        wait_idle();
        send(16'd56, 5);
        wait_idle();

        send(16'd333, int'(TO));
        wait_idle();

        rdy_mode = 1;
        for (int j = 0; j < 30; j++) begin
            int r;
            r = int'($urandom_range(0, 9));
            send(W'($urandom), (r == 0 || r == 9) ? -1 : r);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_idle();
        rdy_mode = 0;

        inject_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("spurious_set", 32'(spurious), 1);
        chk("spurious_no_output", 32'(out_valid), 0);
        exp_spur = 1'b1;
        send(16'd1001, 3);
        wait_idle();

        // Asynchronous reset in the middle of a job
        send(16'd4321, -1);
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk_reset("mid_reset");
        sb.delete();
        exp_jobs = 0;
        exp_spur = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        send(16'd801, 5);
        wait_idle();
        chk("job_cnt_after_reset", 32'(job_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
